// File: rtl/dvp_tx_core_if.sv
// Pixel-stream handshake plus DVP byte bus between the camera emulator and its neighbours.
// The slave modport is the transmitter core, and the master modport is the pixel source / DVP sink side.
interface dvp_tx_core_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int PIXEL_WIDTH = 16
);
    logic [PIXEL_WIDTH-1:0] s_pixel_data;
    logic                   s_pixel_valid;
    logic                   s_pixel_ready;
    logic [DATA_WIDTH-1:0]  cam_half_pixel;
    logic                   cam_href;
    logic                   cam_vsync;

    modport slave (
        input  s_pixel_data,
        input  s_pixel_valid,
        output s_pixel_ready,
        output cam_half_pixel,
        output cam_href,
        output cam_vsync
    );

    modport master (
        output s_pixel_data,
        output s_pixel_valid,
        input  s_pixel_ready,
        input  cam_half_pixel,
        input  cam_href,
        input  cam_vsync
    );
endinterface

// File: rtl/dvp_tx_core.sv
// DVP camera emulator: serializes a 16-bit pixel stream into href/vsync framed bytes,
// high byte first, never stalling a line (missing pixels go out as zero and set underflow).
module dvp_tx_core #(
    parameter int DATA_WIDTH  = 8,
    parameter int PIXEL_WIDTH = 16,
    parameter int VSYNC_PULSE = 10,
    parameter int VBP         = 20,
    parameter int HFP         = 20,
    parameter int HBP         = 20,
    parameter int VFP         = 50
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          start_i,
    input  logic [15:0]   resolution_width_i,
    input  logic [15:0]   resolution_depth_i,
    dvp_tx_core_if.slave  dvp,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          underflow_o
);
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_BLANK = imax(imax(imax(VSYNC_PULSE, VBP), imax(HFP, HBP)), VFP);
    localparam int CNT_W     = $clog2(MAX_BLANK + 1);
    localparam logic [CNT_W-1:0] VSYNC_LAST = CNT_W'(VSYNC_PULSE - 1);
    localparam logic [CNT_W-1:0] VBP_LAST   = CNT_W'(VBP - 1);
    localparam logic [CNT_W-1:0] HFP_LAST   = CNT_W'(HFP - 1);
    localparam logic [CNT_W-1:0] HBP_LAST   = CNT_W'(HBP - 1);
    localparam logic [CNT_W-1:0] VFP_LAST   = CNT_W'(VFP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_VBP, S_HFP, S_ACTIVE, S_HBP, S_VFP
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       blank_cnt_reg;
    logic [16:0]            byte_cnt_reg;
    logic [15:0]            line_cnt_reg;
    logic [15:0]            width_reg;
    logic [15:0]            depth_reg;
    logic [PIXEL_WIDTH-1:0] pix_q_reg;
    logic                   underflow_reg;
    logic                   done_reg;

    logic accept, blank_last, byte_last, line_last, byte_sel;
    logic pixel_ready, href, vsync, busy;

    assign accept    = (state_reg == S_IDLE) && start_i &&
                       (resolution_width_i != 16'd0) && (resolution_depth_i != 16'd0);
    assign byte_last = (byte_cnt_reg == ({width_reg, 1'b0} - 17'd1));
    assign line_last = (line_cnt_reg == (depth_reg - 16'd1));
    assign byte_sel  = byte_cnt_reg[0];

    always_comb begin
        blank_last = 1'b0;
        case (state_reg)
            S_VSYNC: blank_last = (blank_cnt_reg == VSYNC_LAST);
            S_VBP:   blank_last = (blank_cnt_reg == VBP_LAST);
            S_HFP:   blank_last = (blank_cnt_reg == HFP_LAST);
            S_HBP:   blank_last = (blank_cnt_reg == HBP_LAST);
            S_VFP:   blank_last = (blank_cnt_reg == VFP_LAST);
            default: blank_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state_reg <= S_IDLE;
        else           state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept)     state_next = S_VSYNC;
            S_VSYNC:  if (blank_last) state_next = S_VBP;
            S_VBP:    if (blank_last) state_next = S_HFP;
            S_HFP:    if (blank_last) state_next = S_ACTIVE;
            S_ACTIVE: if (byte_last)  state_next = S_HBP;
            S_HBP:    if (blank_last) state_next = line_last ? S_VFP : S_HFP;
            S_VFP:    if (blank_last) state_next = S_IDLE;
            default:                  state_next = S_IDLE;
        endcase
    end

    // Fetch on the last HFP cycle and on every low-byte cycle except the line's final one.
    always_comb begin
        pixel_ready = 1'b0;
        href        = 1'b0;
        vsync       = 1'b1;
        busy        = 1'b1;
        case (state_reg)
            S_IDLE:   busy = 1'b0;
            S_VSYNC:  vsync = 1'b1;
            S_VBP:    vsync = 1'b0;
            S_HFP:    begin vsync = 1'b0; pixel_ready = blank_last; end
            S_ACTIVE: begin vsync = 1'b0; href = 1'b1; pixel_ready = byte_sel && !byte_last; end
            S_HBP:    vsync = 1'b0;
            S_VFP:    vsync = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            blank_cnt_reg <= '0;
            byte_cnt_reg  <= '0;
            line_cnt_reg  <= '0;
            width_reg     <= '0;
            depth_reg     <= '0;
            pix_q_reg     <= '0;
            underflow_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            if (state_next != state_reg || state_reg == S_IDLE || state_reg == S_ACTIVE)
                blank_cnt_reg <= '0;
            else
                blank_cnt_reg <= blank_cnt_reg + 1'b1;

            if (state_reg == S_ACTIVE && state_next == S_ACTIVE)
                byte_cnt_reg <= byte_cnt_reg + 17'd1;
            else
                byte_cnt_reg <= '0;

            if (accept) begin
                width_reg     <= resolution_width_i;
                depth_reg     <= resolution_depth_i;
                line_cnt_reg  <= '0;
                underflow_reg <= 1'b0;
            end else begin
                if (state_reg == S_HBP && state_next == S_HFP)
                    line_cnt_reg <= line_cnt_reg + 16'd1;
                if (pixel_ready && !dvp.s_pixel_valid)
                    underflow_reg <= 1'b1;
            end

            if (pixel_ready)
                pix_q_reg <= dvp.s_pixel_valid ? dvp.s_pixel_data : '0;

            done_reg <= (state_reg == S_VFP) && (state_next == S_IDLE);
        end
    end

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_byte_mux
        assign dvp.cam_half_pixel[gi] = href &&
            (byte_sel ? pix_q_reg[gi] : pix_q_reg[gi + DATA_WIDTH]);
    end

    assign dvp.s_pixel_ready = pixel_ready;
    assign dvp.cam_href      = href;
    assign dvp.cam_vsync     = vsync;
    assign busy_o            = busy;
    assign frame_done_o      = done_reg;
    assign underflow_o       = underflow_reg;
endmodule

// File: tb/tb_dvp_tx_core.sv
// Directed bench for dvp_tx_core: table of whole frames with hand-computed timing,
// plus reset-state, mid-line reset, start guards and back-to-back frame sequences.
module tb_dvp_tx_core;
    logic        clk;
    logic        resetn;
    logic        start;
    logic [15:0] res_w;
    logic [15:0] res_h;
    logic        busy, done, uf;

    dvp_tx_core_if bus ();

    dvp_tx_core dut (
        .clk_i              (clk),
        .resetn_i           (resetn),
        .start_i            (start),
        .resolution_width_i (res_w),
        .resolution_depth_i (res_h),
        .dvp                (bus),
        .busy_o             (busy),
        .frame_done_o       (done),
        .underflow_o        (uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int w; int h; int drop; int restart_at;
        int exp_busy; int exp_width; int exp_pulses; int exp_uf; int exp_uf_off;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // source / monitor state, owned by the single monitor process
    int clr_req = 0;
    int clr_ack = 0;
    int drop_opp = -1;
    int cyc, opp, idx;
    int busy_cnt, done_cnt, pulses, cur_w, min_w, max_w, gap_cur, min_gap, max_gap;
    int t_busy_rise, t_vs_fall, t_href_rise, t_href_fall, t_vs_rise, t_done, t_uf_rise;
    logic prev_busy, prev_vsync, prev_href;
    logic [7:0] got_bytes[$];

    function automatic logic [15:0] pix_val(input int n);
        return 16'(32'h1234 + n * 32'h4444);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        logic hs_opp, hs_take;
        cyc = 0;
        opp = 0; idx = 0;
        bus.s_pixel_data  = pix_val(0);
        bus.s_pixel_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (clr_req != clr_ack) begin
                clr_ack = clr_req;
                opp = 0; idx = 0;
                busy_cnt = 0; done_cnt = 0; pulses = 0; cur_w = 0;
                min_w = 1 << 30; max_w = 0; gap_cur = 0; min_gap = 1 << 30; max_gap = 0;
                t_busy_rise = -1; t_vs_fall = -1; t_href_rise = -1; t_href_fall = -1;
                t_vs_rise = -1; t_done = -1; t_uf_rise = -1;
                prev_busy = 1'b0; prev_vsync = 1'b1; prev_href = 1'b0;
                got_bytes.delete();
                bus.s_pixel_data  = pix_val(0);
                bus.s_pixel_valid = (drop_opp != 0);
            end
            cyc++;
            if (busy) busy_cnt++;
            if (busy && !prev_busy) t_busy_rise = cyc;
            if (!bus.cam_vsync && prev_vsync) t_vs_fall = cyc;
            if (bus.cam_vsync && !prev_vsync) t_vs_rise = cyc;
            if (done) begin done_cnt++; t_done = cyc; end
            if (uf && t_uf_rise < 0) t_uf_rise = cyc;
            if (bus.cam_href) begin
                if (!prev_href) begin
                    if (t_href_rise < 0) t_href_rise = cyc;
                    if (pulses > 0) begin
                        if (gap_cur < min_gap) min_gap = gap_cur;
                        if (gap_cur > max_gap) max_gap = gap_cur;
                    end
                    gap_cur = 0;
                end
                cur_w++;
                got_bytes.push_back(bus.cam_half_pixel);
            end else begin
                if (prev_href) begin
                    pulses++;
                    t_href_fall = cyc;
                    if (cur_w < min_w) min_w = cur_w;
                    if (cur_w > max_w) max_w = cur_w;
                    cur_w = 0;
                end
                gap_cur++;
            end
            prev_busy = busy; prev_vsync = bus.cam_vsync; prev_href = bus.cam_href;
            hs_opp  = bus.s_pixel_ready;
            hs_take = bus.s_pixel_ready && bus.s_pixel_valid;
            @(posedge clk);
            #1;
            if (hs_opp) begin
                if (hs_take) idx++;
                opp++;
            end
            bus.s_pixel_data  = pix_val(idx);
            bus.s_pixel_valid = (opp != drop_opp);
        end
    end

    task automatic clear_mon(input int drop);
        drop_opp = drop;
        clr_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input int w, input int h);
        res_w = 16'(w);
        res_h = 16'(h);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) begin ok = 1; break; end
        end
        chk("done_within_budget", ok, 1);
    endtask

    task automatic check_bytes(input int w, input int h, input int drop);
        logic [7:0] exp_q[$];
        logic [15:0] p;
        int n = 0;
        int errs = 0;
        for (int k = 0; k < w * h; k++) begin
            if (k == drop) begin
                exp_q.push_back(8'h00); exp_q.push_back(8'h00);
            end else begin
                p = pix_val(n);
                n++;
                exp_q.push_back(p[15:8]); exp_q.push_back(p[7:0]);
            end
        end
        chk("byte_count", got_bytes.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_bytes.size(); i++) begin
            if (got_bytes[i] != exp_q[i]) begin
                if (errs == 0)
                    $display("FAIL byte[%0d]: got %02h expected %02h", i, got_bytes[i], exp_q[i]);
                errs++;
            end
        end
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL byte_stream: %0d wrong bytes, required 0", errs);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        clear_mon(v.drop);
        res_w = 16'(v.w);
        res_h = 16'(v.h);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        if (v.restart_at > 0) begin
            repeat (v.restart_at) @(negedge clk);
            #1;
            res_w = 16'd1;
            start = 1'b1;
            @(negedge clk);
            #1;
            start = 1'b0;
        end
        wait_done(1, 4000);
        repeat (3) @(negedge clk);
        #1;
        chk("busy_cycles", busy_cnt, v.exp_busy);
        chk("href_pulses", pulses, v.exp_pulses);
        chk("href_min_width", min_w, v.exp_width);
        chk("href_max_width", max_w, v.exp_width);
        if (v.h > 1) begin
            chk("line_gap_min", min_gap, 40);
            chk("line_gap_max", max_gap, 40);
        end
        chk("vsync_fall_ofs", t_vs_fall - t_busy_rise, 10);
        chk("href_rise_ofs", t_href_rise - t_vs_fall, 40);
        chk("vsync_rise_ofs", t_vs_rise - t_href_fall, 20);
        chk("done_ofs", t_done - t_vs_rise, 50);
        chk("done_pulses", done_cnt, 1);
        chk("underflow", int'(uf), v.exp_uf);
        if (v.exp_uf_off >= 0)
            chk("underflow_rise_ofs", t_uf_rise - t_href_rise, v.exp_uf_off);
        check_bytes(v.w, v.h, v.drop);
        $display("[TB] frame %0d: W=%0d H=%0d busy=%0d pulses=%0d underflow=%0d",
                 id, v.w, v.h, busy_cnt, pulses, uf);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{w:4, h:2, drop:-1, restart_at:0,  exp_busy:176, exp_width:8, exp_pulses:2, exp_uf:0, exp_uf_off:-1};
        vecs[1] = '{w:4, h:1, drop:1,  restart_at:0,  exp_busy:128, exp_width:8, exp_pulses:1, exp_uf:1, exp_uf_off:2};
        vecs[2] = '{w:1, h:3, drop:-1, restart_at:0,  exp_busy:206, exp_width:2, exp_pulses:3, exp_uf:0, exp_uf_off:-1};
        vecs[3] = '{w:3, h:2, drop:0,  restart_at:0,  exp_busy:172, exp_width:6, exp_pulses:2, exp_uf:1, exp_uf_off:0};
        vecs[4] = '{w:4, h:2, drop:-1, restart_at:30, exp_busy:176, exp_width:8, exp_pulses:2, exp_uf:0, exp_uf_off:-1};

        resetn = 1'b0;
        start  = 1'b0;
        res_w  = 16'd0;
        res_h  = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_vsync", int'(bus.cam_vsync), 1);
        chk("rst_href", int'(bus.cam_href), 0);
        chk("rst_data", int'(bus.cam_half_pixel), 0);
        chk("rst_ready", int'(bus.s_pixel_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_underflow", int'(uf), 0);
        $display("[TB] reset state checked");
        #1;
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // zero width or depth never starts a frame
        clear_mon(-1);
        pulse_start(0, 2);
        repeat (10) @(negedge clk);
        #1;
        chk("guard_w0_busy", busy_cnt, 0);
        pulse_start(3, 0);
        repeat (10) @(negedge clk);
        #1;
        chk("guard_h0_busy", busy_cnt, 0);
        $display("[TB] zero-size start requests issued");

        // reset in the middle of an active line
        clear_mon(-1);
        pulse_start(4, 2);
        for (int i = 0; i < 400 && !bus.cam_href; i++) begin
            @(negedge clk);
            #1;
        end
        chk("midline_href_seen", int'(bus.cam_href), 1);
        repeat (3) @(negedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_vsync", int'(bus.cam_vsync), 1);
        chk("midrst_href", int'(bus.cam_href), 0);
        chk("midrst_data", int'(bus.cam_half_pixel), 0);
        chk("midrst_busy", int'(busy), 0);
        #1;
        resetn = 1'b1;
        $display("[TB] mid-line reset applied");
        run_vec(5, vecs[0]);

        // start held high: second frame follows after exactly one idle cycle
        clear_mon(0);
        res_w = 16'd2;
        res_h = 16'd1;
        start = 1'b1;
        wait_done(1, 4000);
        chk("b2b_uf_at_done", int'(uf), 1);
        chk("b2b_busy_at_done", int'(busy), 0);
        @(negedge clk);
        #1;
        chk("b2b_busy_restart", int'(busy), 1);
        chk("b2b_uf_cleared", int'(uf), 0);
        start = 1'b0;
        wait_done(2, 4000);
        repeat (3) @(negedge clk);
        #1;
        chk("b2b_done_pulses", done_cnt, 2);
        chk("b2b_busy_cycles", busy_cnt, 248);
        chk("b2b_uf_final", int'(uf), 0);
        $display("[TB] back-to-back frames: done=%0d busy=%0d", done_cnt, busy_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
